// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator with edge/center-aligned counting and a
// double-buffered configuration that is applied on a period wrap.
module pwm_multichannel #(
  parameter int bitwidth     = 10,
  parameter int channels     = 4,
  parameter int reset_period = 2**bitwidth-1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         update_valid,
  output logic                         update_ready,
  input  logic [bitwidth-1:0]          new_period,
  input  logic                         new_center_aligned,
  input  logic [channels*bitwidth-1:0] new_rising,
  input  logic [channels*bitwidth-1:0] new_falling,
  input  logic [channels-1:0]          new_polarity,
  output logic [bitwidth-1:0]          counter,
  output logic                         period_end,
  output logic [channels-1:0]          generated_signals
);
  localparam logic [bitwidth-1:0] RST_PERIOD = bitwidth'(reset_period);

  // Handshake: a configuration transfers on any clock edge where
  // update_valid && update_ready; update_ready is high whenever the pending slot is empty.

  logic [bitwidth-1:0]          act_period_q, pend_period_q;
  logic                         act_center_q, pend_center_q;
  logic [channels*bitwidth-1:0] act_rise_q, pend_rise_q;
  logic [channels*bitwidth-1:0] act_fall_q, pend_fall_q;
  logic [channels-1:0]          act_pol_q, pend_pol_q;
  logic                         pend_full_q;
  logic [bitwidth-1:0]          cnt_q, cnt_d;
  logic                         dir_up_q, dir_up_d;
  logic [channels-1:0]          gen_q, act_hit;
  logic                         wrap, xfer;

  always_comb begin
    cnt_d    = cnt_q + 1'b1;
    dir_up_d = 1'b1;
    if (!act_center_q) begin
      if (cnt_q >= act_period_q) cnt_d = '0;
    end else if (act_period_q == '0) begin
      cnt_d = '0;
    end else if (dir_up_q && (cnt_q < act_period_q)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d = {{(bitwidth-1){1'b0}}, 1'b1};
    end else begin
      // Descending: turn upward again as soon as the next value is 0.
      cnt_d    = cnt_q - 1'b1;
      dir_up_d = (cnt_d == '0);
    end
  end

  assign wrap = enable && (cnt_d == '0);
  assign xfer = pend_full_q && (wrap || !enable);

  always_comb begin
    act_hit = '0;
    for (int k = 0; k < channels; k++) begin
      act_hit[k] = (act_rise_q[k*bitwidth +: bitwidth] <= cnt_q) &&
                   (cnt_q < act_fall_q[k*bitwidth +: bitwidth]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      act_period_q  <= RST_PERIOD;
      act_center_q  <= 1'b0;
      act_rise_q    <= '0;
      act_fall_q    <= '0;
      act_pol_q     <= '0;
      pend_period_q <= '0;
      pend_center_q <= 1'b0;
      pend_rise_q   <= '0;
      pend_fall_q   <= '0;
      pend_pol_q    <= '0;
      pend_full_q   <= 1'b0;
      cnt_q         <= '0;
      dir_up_q      <= 1'b1;
      gen_q         <= '0;
    end else begin
      if (xfer) begin
        act_period_q <= pend_period_q;
        act_center_q <= pend_center_q;
        act_rise_q   <= pend_rise_q;
        act_fall_q   <= pend_fall_q;
        act_pol_q    <= pend_pol_q;
        pend_full_q  <= 1'b0;
        cnt_q        <= '0;
        dir_up_q     <= 1'b1;
      end else if (enable) begin
        cnt_q    <= cnt_d;
        dir_up_q <= dir_up_d;
      end
      // Capture and transfer are exclusive: capture needs an empty slot.
      if (update_valid && !pend_full_q) begin
        pend_period_q <= new_period;
        pend_center_q <= new_center_aligned;
        pend_rise_q   <= new_rising;
        pend_fall_q   <= new_falling;
        pend_pol_q    <= new_polarity;
        pend_full_q   <= 1'b1;
      end
      gen_q <= enable ? (act_hit ^ act_pol_q) : act_pol_q;
    end
  end

  assign update_ready      = !pend_full_q;
  assign counter           = cnt_q;
  assign period_end        = wrap;
  assign generated_signals = gen_q;
endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: a cycle-level reference of the counter
// sequence and configuration buffering feeds an expected-output queue.
module tb_pwm_multichannel;
  localparam int BW = 4;
  localparam int CH = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             update_valid = 1'b0;
  logic             update_ready;
  logic [BW-1:0]    new_period = '0;
  logic             new_center_aligned = 1'b0;
  logic [CH*BW-1:0] new_rising = '0;
  logic [CH*BW-1:0] new_falling = '0;
  logic [CH-1:0]    new_polarity = '0;
  logic [BW-1:0]    counter;
  logic             period_end;
  logic [CH-1:0]    generated_signals;

  always #5 clock = ~clock;

  pwm_multichannel #(.bitwidth(BW), .channels(CH)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .update_valid(update_valid), .update_ready(update_ready),
    .new_period(new_period), .new_center_aligned(new_center_aligned),
    .new_rising(new_rising), .new_falling(new_falling),
    .new_polarity(new_polarity), .counter(counter),
    .period_end(period_end), .generated_signals(generated_signals)
  );

  int checks = 0;
  int errors = 0;
  logic [CH-1:0] exp_q[$];

  // Reference state: active set (m_*), pending set (p_*), position in sequence.
  int               pos;
  logic [BW-1:0]    m_per, p_per;
  logic             m_ctr, p_ctr;
  logic [CH*BW-1:0] m_r, m_f, p_r, p_f;
  logic [CH-1:0]    m_pol, p_pol;
  logic             m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int seq_len();
    if (m_ctr) return (m_per == '0) ? 1 : 2 * int'(m_per);
    return int'(m_per) + 1;
  endfunction

  function automatic logic [BW-1:0] exp_cnt();
    int c;
    if (m_ctr && pos > int'(m_per)) c = 2 * int'(m_per) - pos;
    else c = pos;
    return BW'(c);
  endfunction

  function automatic logic [CH-1:0] exp_gen(input logic [BW-1:0] c);
    logic [CH-1:0] g;
    g = '0;
    for (int k = 0; k < CH; k++)
      g[k] = ((m_r[k*BW +: BW] <= c) && (c < m_f[k*BW +: BW])) ^ m_pol[k];
    return g;
  endfunction

  task automatic step();
    logic [BW-1:0] c;
    logic          wrap, accept, xfer;
    logic [CH-1:0] g;
    c    = exp_cnt();
    wrap = enable && (pos == seq_len() - 1);
    chk("counter", counter, c);
    chk("period_end", period_end, wrap);
    chk("ready", update_ready, !m_pend);
    exp_q.push_back(enable ? exp_gen(c) : m_pol);
    accept = update_valid && !m_pend;
    xfer   = m_pend && (wrap || !enable);
    @(posedge clock); #1;
    if (xfer) begin
      m_per = p_per; m_ctr = p_ctr; m_r = p_r; m_f = p_f; m_pol = p_pol;
      m_pend = 1'b0;
      pos = 0;
    end else if (enable) begin
      pos = (pos + 1) % seq_len();
    end
    if (accept) begin
      p_per = new_period; p_ctr = new_center_aligned;
      p_r = new_rising; p_f = new_falling; p_pol = new_polarity;
      m_pend = 1'b1;
    end
    update_valid = 1'b0;
    g = exp_q.pop_front();
    chk("generated", generated_signals, g);
  endtask

  task automatic offer(input logic [BW-1:0] per, input logic ctr,
                       input logic [CH*BW-1:0] r, input logic [CH*BW-1:0] f,
                       input logic [CH-1:0] pol);
    new_period = per; new_center_aligned = ctr;
    new_rising = r; new_falling = f; new_polarity = pol;
    update_valid = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    update_valid = 1'b0;
    pos = 0; m_per = 4'd15; m_ctr = 1'b0; m_r = '0; m_f = '0; m_pol = '0;
    m_pend = 1'b0;
    exp_q.delete();
    chk("rst_counter", counter, 0);
    chk("rst_generated", generated_signals, 0);
    chk("rst_ready", update_ready, 1);
  endtask

  task automatic run_until(input logic [BW-1:0] v);
    for (int i = 0; i < 64 && exp_cnt() != v; i++) step();
  endtask

  task automatic run_until_wrap();
    for (int i = 0; i < 64 && pos != seq_len() - 1; i++) step();
  endtask

  initial begin
    logic [BW-1:0] ra, fa, rb, fb;
    ra = BW'($urandom_range(0, 9));
    fa = BW'($urandom_range(0, 12));
    rb = BW'($urandom_range(0, 9));
    fb = BW'($urandom_range(0, 12));
    do_reset();
    step();

    // Edge mode period 9, ch0 2..4; ch2/ch3 random windows.
    offer(4'd9, 1'b0, {rb, ra, 4'd0, 4'd2}, {fb, fa, 4'd0, 4'd5}, 4'b0000);
    step();
    step();
    enable = 1'b1;
    repeat (25) step();

    // Update at count 3; a second offer while pending must be dropped.
    run_until(4'd3);
    offer(4'd9, 1'b0, {rb, ra, 4'd0, 4'd0}, {fb, fa, 4'd0, 4'd9}, 4'b0000);
    step();
    run_until(4'd6);
    offer(4'd9, 1'b0, {4'd0, 4'd0, 4'd0, 4'd7}, {4'd0, 4'd0, 4'd0, 4'd8}, 4'b1111);
    step();
    repeat (20) step();

    // Center mode period 4: ch1 1..2, ch2 falling beyond period, ch3 rising>=falling.
    offer(4'd4, 1'b1, {4'd3, 4'd0, 4'd1, 4'd0}, {4'd2, 4'd7, 4'd3, 4'd0}, 4'b0000);
    step();
    repeat (28) step();

    // Center mode period 1, then edge mode period 0.
    offer(4'd1, 1'b1, {4'd0, 4'd0, 4'd1, 4'd0}, {4'd0, 4'd0, 4'd2, 4'd1}, 4'b0000);
    step();
    repeat (12) step();
    offer(4'd0, 1'b0, {4'd0, 4'd0, 4'd0, 4'd0}, {4'd0, 4'd0, 4'd0, 4'd1}, 4'b0100);
    step();
    repeat (6) step();

    // Active-low channels, empty window on ch0, then an enable pause.
    offer(4'd9, 1'b0, {4'd0, 4'd0, 4'd2, 4'd6}, {4'd0, 4'd0, 4'd5, 4'd3}, 4'b0011);
    step();
    repeat (16) step();
    enable = 1'b0;
    repeat (4) step();
    enable = 1'b1;
    repeat (6) step();

    // Offer landing exactly on a wrap cycle is only captured there.
    run_until_wrap();
    offer(4'd5, 1'b0, {4'd0, 4'd0, 4'd0, 4'd1}, {4'd0, 4'd0, 4'd0, 4'd4}, 4'b0000);
    step();
    repeat (16) step();

    // Reset mid-period with an update pending and another offered.
    run_until(4'd2);
    offer(4'd3, 1'b1, {4'd0, 4'd0, 4'd0, 4'd1}, {4'd0, 4'd0, 4'd0, 4'd2}, 4'b1111);
    step();
    step();
    update_valid = 1'b1;
    do_reset();
    repeat (18) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_multichannel.md
PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

Interface
REQ-001 Parameter bitwidth, default 10: width of the counter, period and edge values.
REQ-002 Parameter channels, default 4: number of independent pulse outputs.
REQ-003 Parameter reset_period, default 2**bitwidth-1: period loaded at reset.
REQ-004 clock  in  1  sole clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 enable  in  1  1 = counter runs; 0 = counter holds and outputs are inactive.
REQ-007 update_valid  in  1  new configuration offered.
REQ-008 update_ready  out  1  pending slot free; transfer occurs when valid&ready at a clock edge.
REQ-009 new_period  in  bitwidth  period for the offered configuration.
REQ-010 new_center_aligned  in  1  counting mode for the offered configuration: 0 = edge, 1 = center.
REQ-011 new_rising  in  channels*bitwidth  per-channel rising-edge tick; channel k uses bits [k*bitwidth +: bitwidth].
REQ-012 new_falling  in  channels*bitwidth  per-channel falling-edge tick, packed the same way.
REQ-013 new_polarity  in  channels  per-channel output inversion; 1 = active-low.
REQ-014 counter  out  bitwidth  current counter value.
REQ-015 period_end  out  1  high during the wrap cycle.
REQ-016 generated_signals  out  channels  registered PWM outputs.

Function
REQ-017 Three register sets: incoming configuration, pending, active; only the active set drives the counter and comparators.
REQ-018 Edge mode: counter sequence 0,1,...,period,0,...
REQ-019 Center mode: counter counts up 0..period, then down period-1..1, then returns to 0; a direction flag flips at period and at 0.
REQ-020 Center mode with period 1: sequence is 0,1,0,1.
REQ-021 Period 0 in either mode: counter stays 0 and every enabled cycle is a wrap cycle.
REQ-022 Wrap cycle: the enabled cycle whose next counter value is 0; period_end is 1 in exactly that cycle and 0 otherwise.
REQ-023 Channel k active when rising_k <= counter < falling_k, evaluated in both modes.
REQ-024 If rising_k >= falling_k, channel k is never active.
REQ-025 If falling_k > period, channel k stays active through the wrap cycle.
REQ-026 generated_signals[k] <= active_k XOR polarity_k: one clock of latency from counter to output.
REQ-027 Handshake: update_ready = !pending_full; on valid&ready, all new_* inputs are captured into the pending set and pending_full is set.
REQ-028 update_valid while update_ready=0: ignored; no stall and no overwrite of the pending set.
REQ-029 Transfer rule: on the clock edge ending a wrap cycle with pending_full=1:
  - pending set is copied into the active set;
  - pending_full is cleared;
  - counter goes to 0 with direction up.
REQ-030 Transfer and capture in the same wrap cycle (ready=1, valid=1): the value is captured only and applied at the following wrap.
REQ-031 enable=0:
  - counter and direction hold;
  - period_end=0;
  - generated_signals[k] = polarity_k (inactive level), registered;
  - a pending set transfers to the active set on the next edge without waiting for a wrap.
REQ-032 enable rising: counting resumes from the held value; the first output reflects the held counter one cycle later.
REQ-033 Mode or period change applies only at a transfer; counter arithmetic wraps modulo 2**bitwidth and never exceeds the active period.

Reset
REQ-034 Reset state:
  - counter=0, direction up, period_end=0, generated_signals=0;
  - active period=reset_period, active mode edge, all rising/falling=0, polarity=0;
  - pending_full=0, so update_ready=1.
REQ-035 Reset has priority over enable and the handshake; reset mid-period discards any pending set.

Verification
REQ-036 bitwidth=4, period 9, edge mode, ch0 rising 2 / falling 5 -> counter 0..9 repeating, ch0 high for counter 2,3,4 (one cycle late), period_end when counter=9.
REQ-037 Center mode, period 4, ch1 rising 1 / falling 3 -> counter 0,1,2,3,4,3,2,1,0; ch1 high at counts 1,2,2,1.
REQ-038 Update offered at counter=3 (period 9) with new rising 0 / falling 9 -> ready falls, active set unchanged until the edge after counter=9, then ch0 high for counts 0..8; ready returns to 1.
REQ-039 Second update offered while ready=0 -> ignored; first update applied at the wrap.
REQ-040 Polarity 1, enable=0 -> output 1; rising 6 / falling 3 -> output constantly inactive.
REQ-041 Reset asserted mid-period with an update pending -> next cycle counter=0, outputs 0, ready=1, period=reset_period.
